// File: rtl/alu_exec32.sv
// Execute stage: single-cycle ALU ops plus an iterative 1-bit-per-cycle shifter,
// with a valid/ready handshake on both sides and one op in flight at a time.
module alu_exec32 #(
   parameter int XLEN     = 32,
   parameter int OP_WIDTH = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [OP_WIDTH-1:0] op,
   input  logic [XLEN-1:0]     a,
   input  logic [XLEN-1:0]     b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     result,
   output logic                err
);

   localparam int SHW = $clog2(XLEN);
   localparam logic [SHW-1:0]      SH_ONE = SHW'(1);
   localparam logic [OP_WIDTH-1:0] OP_ONE = OP_WIDTH'(1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t          r_state;
   state_t          w_nextState;
   logic [XLEN-1:0] r_result;
   logic            r_err;
   logic [SHW-1:0]  r_count;
   logic            r_shLeft;
   logic            r_shArith;

   logic            w_accept;
   logic            w_oneHot;
   logic            w_isShift;
   logic [SHW-1:0]  w_shamt;
   logic [XLEN-1:0] w_alu;
   logic [XLEN-1:0] w_shifted;

   assign w_accept  = in_valid && (r_state == IDLE);
   assign w_oneHot  = (op != '0) && ((op & (op - OP_ONE)) == '0);
   assign w_isShift = |op[7:5];
   assign w_shamt   = b[SHW-1:0];

   // Only evaluated for legal one-hot ops, so bit priority is irrelevant.
   always_comb begin
      w_alu = '0;
      if (op[0])      w_alu = a + b;
      else if (op[1]) w_alu = a - b;
      else if (op[2]) w_alu = a ^ b;
      else if (op[3]) w_alu = a | b;
      else if (op[4]) w_alu = a & b;
      else if (op[8]) w_alu = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      else if (op[9]) w_alu = {{(XLEN-1){1'b0}}, (a < b)};
   end

   assign w_shifted = r_shLeft ? {r_result[XLEN-2:0], 1'b0}
                               : {r_shArith & r_result[XLEN-1], r_result[XLEN-1:1]};

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_oneHot && w_isShift && (w_shamt != '0)) w_nextState = SHIFT;
               else                                          w_nextState = DONE;
            end
         end
         SHIFT: begin
            if (r_count == SH_ONE) w_nextState = DONE;
         end
         DONE: begin
            if (out_ready) w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // The result register doubles as the shift register while in SHIFT.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_result  <= '0;
         r_err     <= 1'b0;
         r_count   <= '0;
         r_shLeft  <= 1'b0;
         r_shArith <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_shLeft  <= op[5];
                  r_shArith <= op[7];
                  r_count   <= w_shamt;
                  if (!w_oneHot) begin
                     r_err    <= 1'b1;
                     r_result <= '0;
                  end else if (w_isShift) begin
                     r_err    <= 1'b0;
                     r_result <= a;
                  end else begin
                     r_err    <= 1'b0;
                     r_result <= w_alu;
                  end
               end
            end
            SHIFT: begin
               r_result <= w_shifted;
               r_count  <= r_count - SH_ONE;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign result    = r_result;
   assign err       = r_err;

endmodule
